// File: rtl/xnor_pop_pkg.sv
// Shared constants for the XNOR/XOR popcount accumulator: operand modes,
// FSM state encoding and a width helper.
package xnor_pop_pkg;

  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_XOR  = 1'b1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Bits needed to hold values 0..n-1; bounded loop keeps it elaboration-friendly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount
  import xnor_pop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Streams operand pairs, accumulates per-beat XNOR match / XOR mismatch counts
// over a burst and presents the saturating total on a valid/ready result port.
module xnor_popcount_acc
  import xnor_pop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [ACC_W-1:0] out_beats,
  output logic             out_sat
);

  localparam int PW = clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   beats_q, beats_d;
  logic               sat_q, sat_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [ACC_W-1:0]   out_beats_q, out_beats_d;
  logic               out_sat_q, out_sat_d;

  logic               accept;
  logic               mode_eff;
  logic [WIDTH-1:0]   cmp_bits;
  logic [PW-1:0]      pop;
  logic [ACC_W:0]     acc_nx;
  logic [ACC_W:0]     beats_nx;
  logic               sat_nx;

  // Returns {overflowed, clamped sum}; clamps to all ones when the carry is set.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign mode_eff  = (beats_q == '0) ? mode : mode_q;

  // Operands are gated by accept so idle/X inputs never reach the adder tree.
  always_comb begin
    cmp_bits = '0;
    if (accept) begin
      cmp_bits = (mode_eff == MODE_XOR) ? (in_a ^ in_b) : ~(in_a ^ in_b);
    end
  end

  popcount #(
    .WIDTH (WIDTH),
    .CNT_W (PW)
  ) u_popcount (
    .bits_i  (cmp_bits),
    .count_o (pop)
  );

  assign acc_nx   = sat_add(acc_q, ACC_W'(pop));
  assign beats_nx = sat_add(beats_q, ACC_W'(1));
  assign sat_nx   = sat_q | acc_nx[ACC_W] | beats_nx[ACC_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    sat_d       = sat_q;
    mode_d      = mode_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          mode_d = mode_eff;
          if (in_last) begin
            out_sum_d   = acc_nx[ACC_W-1:0];
            out_beats_d = beats_nx[ACC_W-1:0];
            out_sat_d   = sat_nx;
            acc_d       = '0;
            beats_d     = '0;
            sat_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d   = acc_nx[ACC_W-1:0];
            beats_d = beats_nx[ACC_W-1:0];
            sat_d   = sat_nx;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      beats_q     <= '0;
      sat_q       <= 1'b0;
      mode_q      <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      sat_q       <= sat_d;
      mode_q      <= mode_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/xnor_popcount_acc.md
Name: xnor_popcount_acc

Overview:
- Parametrised, clocked successor to the single-bit XNOR gate.
- Takes WIDTH-bit operand pairs over a valid/ready stream and computes per-beat popcount of XNOR(A,B) (match count) or XOR(A,B) (mismatch / Hamming distance).
- Accumulates the counts across a burst terminated by in_last, then emits the sum on a valid/ready result port.
- Used as the binarised dot-product / Hamming-distance primitive in the logic datapath.

Parameters:
- WIDTH, 8, operand width in bits (>=1).
- ACC_W, 16, accumulator and beat-counter width in bits (>= clog2(WIDTH+1)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_last  in  1  final beat of the burst.
- mode  in  1  0 = XNOR match count, 1 = XOR mismatch count; sampled on the first beat of a burst.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  accumulated count, saturating.
- out_beats  out  ACC_W  beats in the burst, saturating.
- out_sat  out  1  sum or beat count saturated during this burst.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to ACCUM.
  - Accumulator, beat counter, latched mode, out_sum, out_beats, out_sat and out_valid all go to 0.
  - in_ready = 1 from the first cycle after reset.
  - A reset mid-burst or mid-HOLD discards all partial or pending data.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
  - in_ready is a pure function of state.
- Beat accept: in_valid && in_ready at a rising edge.
  - p = popcount(mode_eff ? A^B : ~(A^B)), width clog2(WIDTH+1).
  - mode_eff = mode on the first beat of a burst (beat counter == 0), otherwise the latched mode. mode changes mid-burst are ignored.
- Accumulate: acc_next = acc + p, zero-extended to ACC_W+1.
  - If the result exceeds 2^ACC_W-1, acc becomes all ones and the sticky saturation flag is set.
  - The beat counter increments with the same saturate rule and sets the same flag.
- Accepted beat with in_last = 1:
  - Final sum, beat count and saturation flag (including this beat) load into out_sum/out_beats/out_sat.
  - Accumulator, beat counter and sticky flag clear.
  - State goes to HOLD.
  - Latency: out_valid is high in the cycle after the last-beat edge.
- HOLD:
  - out_sum, out_beats and out_sat stay stable while out_valid && !out_ready.
  - On out_valid && out_ready at an edge: out_valid goes to 0, state goes to ACCUM, and in_ready is 1 the next cycle.
  - The no-accept cycle in HOLD is deliberate: at most one burst every beats+1 cycles.
- out_sum, out_beats and out_sat keep their last values after handshake (not cleared) until the next load or reset.
- in_valid while in_ready = 0 has no effect; the upstream holds its data.
- Single-beat burst: beat counter 0 with in_last = 1 gives out_beats = 1.
- A in_valid && in_last beat with no prior beats is legal.
- in_a/in_b/in_last/mode are ignored when not accepted. X on them when in_valid = 0 must not propagate.

Decomposition:
- Package xnor_pop_pkg:
  - mode constants MODE_XNOR = 1'b0, MODE_XOR = 1'b1.
  - state encoding ST_ACCUM, ST_HOLD.
  - a clog2 constant function.
- Sub-module popcount:
  - parameter WIDTH, input WIDTH bits, output clog2(WIDTH+1) bits.
  - purely combinational, instantiated once.
- Top module holds the FSM, accumulator, beat counter and output register.

Test Plan:
1. WIDTH=8, ACC_W=16; one beat A=8'hF0, B=8'hF0, last=1, mode=0, out_ready=1 -> next cycle out_valid=1, out_sum=8, out_beats=1, out_sat=0; in_ready returns 1 one cycle after handshake.
2. A=8'hAA, B=8'h55, last=1: mode=0 -> out_sum=0; repeat with mode=1 -> out_sum=8.
3. 3-beat burst, mode=0 on beat 1 and mode=1 on beats 2–3: (FF,00), (0F,0F), (F0,0F, last) -> out_sum=0+8+0=8 (mode held XNOR), out_beats=3; in_valid gaps between beats do not alter the result.
4. Backpressure: after a last beat hold out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, out_sum stable, offered beats not accepted; raise out_ready -> handshake, in_ready=1 next cycle.
5. WIDTH=8, ACC_W=4: two beats A=B=8'hFF, second last -> 8+8=16 saturates: out_sum=15, out_sat=1, out_beats=2; next burst (one beat A=B=8'h01) gives out_sum=8, out_sat=0.
6. Reset mid-burst: accept 2 beats, pull rst_n low 1 cycle -> out_valid=0, out_sum=0, out_beats=0; then one beat A=B=8'hFF, last -> out_sum=8, out_beats=1.
